// File: rtl/cpu_phase_gen.sv
// cpu_phase_gen: eight-phase instruction-cycle timing generator.
// A 3-bit phase counter is stepped through the eight phases of each
// instruction, decoded into a registered one-hot vector and a few
// datapath strobes, with stall/halt control from the instruction decoder.
module cpu_phase_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       halt,
  output logic [2:0] phase_code,
  output logic [7:0] phase_onehot,
  output logic       fetch,
  output logic       alu_ena,
  output logic       wb_ena,
  output logic       cycle_done,
  output logic       running,
  output logic       halted,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] phase_code_q, phase_code_d;
  logic [7:0] phase_onehot_q, phase_onehot_d;
  logic       cycle_done_q, cycle_done_d;
  logic [7:0] instr_count_q, instr_count_d;

  // Halt is effectively pending if already latched (HALTING) or requested now in RUN.
  logic halt_eff;
  assign halt_eff = (state_q == HALTING) || ((state_q == RUN) && halt);

  // Next-state logic: start, stall hold, phase advance and instruction completion.
  always_comb begin
    state_d        = state_q;
    phase_code_d   = phase_code_q;
    phase_onehot_d = phase_onehot_q;
    cycle_done_d   = 1'b0;
    instr_count_d  = instr_count_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d        = RUN;
          phase_code_d   = 3'd0;
          phase_onehot_d = 8'h01;
        end
      end
      RUN, HALTING: begin
        if (stall) begin
          // Phase holds; a halt request arriving with the stall is still latched.
          state_d = halt_eff ? HALTING : RUN;
        end else if (phase_code_q == 3'd7) begin
          // Completion edge: the instruction retires here.
          cycle_done_d  = 1'b1;
          instr_count_d = instr_count_q + 8'd1;
          phase_code_d  = 3'd0;
          if (halt_eff) begin
            state_d        = HALTED;
            phase_onehot_d = 8'h00;
          end else begin
            state_d        = RUN;
            phase_onehot_d = 8'h01;
          end
        end else begin
          state_d        = halt_eff ? HALTING : RUN;
          phase_code_d   = phase_code_q + 3'd1;
          phase_onehot_d = 8'h01 << (phase_code_q + 3'd1);
        end
      end
      default: begin
        state_d        = IDLE;
        phase_code_d   = 3'd0;
        phase_onehot_d = 8'h00;
      end
    endcase
  end

  // State and output registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_code_q   <= 3'd0;
      phase_onehot_q <= 8'h00;
      cycle_done_q   <= 1'b0;
      instr_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      phase_code_q   <= phase_code_d;
      phase_onehot_q <= phase_onehot_d;
      cycle_done_q   <= cycle_done_d;
      instr_count_q  <= instr_count_d;
    end
  end

  assign phase_code   = phase_code_q;
  assign phase_onehot = phase_onehot_q;
  assign cycle_done   = cycle_done_q;
  assign instr_count  = instr_count_q;

  // Strobes are plain decodes of the registered one-hot vector.
  assign fetch   = phase_onehot_q[0] | phase_onehot_q[1];
  assign alu_ena = phase_onehot_q[3];
  assign wb_ena  = phase_onehot_q[6];
  assign running = (state_q == RUN) || (state_q == HALTING);
  assign halted  = (state_q == HALTED);

endmodule
